// File: rtl/rtc_bus_arbiter.sv
// Three-way arbiter for the single RTC bus port: one-hot grant, watchdog revocation, one-cycle gap between owners.
// Optional round-robin selection is enabled with the RTC_ARB_RR_EN macro; otherwise fixed priority 0 > 1 > 2.
module rtc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  done,
    input  logic [23:0] dir_in,
    input  logic [23:0] dato_in,
    input  logic [2:0]  le_in,
    input  logic        siga,
    input  logic        tome,
    output logic [2:0]  grant,
    output logic [7:0]  direc,
    output logic [7:0]  dato_smh,
    output logic        lea_escriba,
    output logic        flag_rtc,
    output logic [2:0]  siga_o,
    output logic [2:0]  tome_o,
    output logic        timeout,
    output logic [1:0]  timeout_id,
    output logic [3:0]  auxiliar
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_grant;
    logic [2:0]  w_grant_nxt;
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_nxt;
    logic        r_timeout;
    logic        w_timeout_nxt;
    logic [1:0]  r_timeout_id;
    logic [1:0]  w_timeout_id_nxt;

    logic [1:0]  w_winner_idx;
    logic [2:0]  w_winner_oh;
    logic [1:0]  w_gidx;
    logic        w_release;
    logic        w_expire;
    logic        w_take;

    assign w_take = (r_state == ST_IDLE) && (req != 3'b000);

`ifdef RTC_ARB_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_cand [3];

    // Candidate k is (pointer + k + 1) mod 3; pointer never exceeds 2 so one wrap suffices.
    function automatic logic [1:0] rr_add(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            assign w_cand[gi] = rr_add(r_ptr, 2'(gi + 1));
        end
    endgenerate

    always_comb begin
        w_winner_idx = w_cand[2];
        for (int k = 2; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_winner_idx = w_cand[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= 2'd2;
        end else if (w_take) begin
            r_ptr <= w_winner_idx;
        end
    end
`else
    always_comb begin
        if (req[0]) begin
            w_winner_idx = 2'd0;
        end else if (req[1]) begin
            w_winner_idx = 2'd1;
        end else begin
            w_winner_idx = 2'd2;
        end
    end
`endif

    assign w_winner_oh = 3'b001 << w_winner_idx;

    always_comb begin
        if (r_grant[1]) begin
            w_gidx = 2'd1;
        end else if (r_grant[2]) begin
            w_gidx = 2'd2;
        end else begin
            w_gidx = 2'd0;
        end
    end

    // A voluntary release outranks watchdog expiry in the same cycle.
    assign w_release = done[w_gidx] | ~req[w_gidx];
    assign w_expire  = (r_wdog == LP_WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 3'b000;
            r_wdog       <= 16'd0;
            r_timeout    <= 1'b0;
            r_timeout_id <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_wdog       <= w_wdog_nxt;
            r_timeout    <= w_timeout_nxt;
            r_timeout_id <= w_timeout_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_wdog_nxt       = r_wdog;
        w_timeout_nxt    = 1'b0;
        w_timeout_id_nxt = r_timeout_id;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 3'b000;
                if (w_take) begin
                    w_grant_nxt = w_winner_oh;
                    w_wdog_nxt  = 16'd0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_wdog_nxt = r_wdog + 16'd1;
                if (w_release) begin
                    w_grant_nxt = 3'b000;
                    w_state_nxt = ST_GAP;
                end else if (w_expire) begin
                    w_grant_nxt      = 3'b000;
                    w_state_nxt      = ST_GAP;
                    w_timeout_nxt    = 1'b1;
                    w_timeout_id_nxt = w_gidx;
                end
            end
            ST_GAP: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = 3'b000;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus mux is purely combinational so the owner's inputs pass through with no added latency.
    always_comb begin
        direc       = 8'h00;
        dato_smh    = 8'h00;
        lea_escriba = 1'b1;
        flag_rtc    = 1'b0;
        if (r_state == ST_BUSY) begin
            direc       = dir_in[{w_gidx, 3'b000} +: 8];
            dato_smh    = dato_in[{w_gidx, 3'b000} +: 8];
            lea_escriba = le_in[w_gidx];
            flag_rtc    = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_hs
            assign siga_o[gi] = siga & r_grant[gi];
            assign tome_o[gi] = tome & r_grant[gi];
        end
    endgenerate

    assign grant      = r_grant;
    assign timeout    = r_timeout;
    assign timeout_id = r_timeout_id;
    assign auxiliar   = {2'b00, r_state};

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized scoreboard bench for rtc_bus_arbiter against an owner/hold-count reference model.
module tb_rtc_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, done, le_in;
    logic [23:0] dir_in, dato_in;
    logic        siga, tome;
    logic [2:0]  grant, siga_o, tome_o;
    logic [7:0]  direc, dato_smh;
    logic        lea_escriba, flag_rtc, timeout;
    logic [1:0]  timeout_id;
    logic [3:0]  auxiliar;

    rtc_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .dir_in(dir_in), .dato_in(dato_in), .le_in(le_in),
        .siga(siga), .tome(tome),
        .grant(grant), .direc(direc), .dato_smh(dato_smh),
        .lea_escriba(lea_escriba), .flag_rtc(flag_rtc),
        .siga_o(siga_o), .tome_o(tome_o),
        .timeout(timeout), .timeout_id(timeout_id), .auxiliar(auxiliar)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] grant;
        logic [7:0] direc;
        logic [7:0] dato;
        logic       le;
        logic       flag;
        logic [2:0] siga_o;
        logic [2:0] tome_o;
        logic       to;
        logic [1:0] toid;
        logic [3:0] aux;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("grant",       32'(grant),       32'(e.grant));
                check("direc",       32'(direc),       32'(e.direc));
                check("dato_smh",    32'(dato_smh),    32'(e.dato));
                check("lea_escriba", 32'(lea_escriba), 32'(e.le));
                check("flag_rtc",    32'(flag_rtc),    32'(e.flag));
                check("siga_o",      32'(siga_o),      32'(e.siga_o));
                check("tome_o",      32'(tome_o),      32'(e.tome_o));
                check("timeout",     32'(timeout),     32'(e.to));
                check("timeout_id",  32'(timeout_id),  32'(e.toid));
                check("auxiliar",    32'(auxiliar),    32'(e.aux));
                $display("cyc=%0d req=%b done=%b grant=%b to=%b toid=%0d aux=%0d",
                         cyc, req, done, grant, timeout, timeout_id, auxiliar);
                cyc++;
            end
        end
    end

    // Reference model: who owns the bus, for how many cycles, and what happened last.
    int m_phase;   // 0 idle, 1 owned, 2 gap
    int m_owner;
    int m_held;    // cycles owned including the current one
    int m_last;
    bit m_to;
    int m_toid;

    function automatic int pick(input logic [2:0] r);
`ifdef RTC_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            if (r[(m_last + k) % 3]) return (m_last + k) % 3;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    initial begin
        exp_t e;
        logic [2:0] req_lvl;
        int w;
        reset = 1'b0;
        req = '0; done = '0; le_in = '0; dir_in = '0; dato_in = '0; siga = 0; tome = 0;
        m_phase = 0; m_owner = 0; m_held = 0; m_last = 2; m_to = 0; m_toid = 0;
        req_lvl = 3'b000;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 1670; c++) begin
            dir_in  = 24'($urandom);
            dato_in = 24'($urandom);
            le_in   = 3'($urandom);
            siga    = 1'($urandom);
            tome    = 1'($urandom);
            done    = 3'b000;
            if (c < 20) begin
                req = 3'b000;
            end else if (c < 40) begin
                req = 3'b010;
                dir_in[15:8]  = 8'h21;
                dato_in[15:8] = 8'h45;
                done[1] = (m_phase == 1 && m_owner == 1 && m_held == 4);
            end else if (c < 100) begin
                req = 3'b111;
                if (m_phase == 1 && m_held == 5) done[m_owner] = 1'b1;
            end else if (c < 130) begin
                req = 3'b100;
            end else if (c < 170) begin
                req = 3'b100;
                done[2] = (m_phase == 1 && m_owner == 2 && m_held == TO);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if ($urandom_range(0, 9) == 0) req_lvl[i] = ~req_lvl[i];
                    done[i] = ($urandom_range(0, 7) == 0);
                end
                req = req_lvl;
            end

            // Expected outputs for this cycle.
            e = '0;
            e.le   = 1'b1;
            e.to   = m_to;
            e.toid = 2'(m_toid);
            e.aux  = 4'(m_phase);
            if (m_phase == 1) begin
                e.grant  = 3'(1 << m_owner);
                e.direc  = dir_in[8*m_owner +: 8];
                e.dato   = dato_in[8*m_owner +: 8];
                e.le     = le_in[m_owner];
                e.flag   = 1'b1;
                e.siga_o = siga ? e.grant : 3'b000;
                e.tome_o = tome ? e.grant : 3'b000;
            end
            q.push_back(e);

            // Advance the model across the coming clock edge.
            m_to = 0;
            case (m_phase)
                0: if (req != 3'b000) begin
                    w = pick(req);
                    m_owner = w; m_last = w; m_held = 1; m_phase = 1;
                end
                1: if (done[m_owner] || !req[m_owner]) begin
                    m_phase = 2;
                end else if (m_held == TO) begin
                    m_phase = 2; m_to = 1; m_toid = m_owner;
                end else begin
                    m_held++;
                end
                default: m_phase = 0;
            endcase
            @(negedge clk);
        end

        req = 3'b000; done = 3'b000;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) check("drain", 32'(q.size()), 32'd0);

        // Asynchronous reset while requester 0 holds the bus.
        repeat (4) @(negedge clk);
        req = 3'b001;
        @(negedge clk);
        #1;
        check("rst_pre_grant", 32'(grant), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst_grant",    32'(grant),       32'd0);
        check("rst_flag",     32'(flag_rtc),    32'd0);
        check("rst_direc",    32'(direc),       32'd0);
        check("rst_le",       32'(lea_escriba), 32'd1);
        check("rst_aux",      32'(auxiliar),    32'd0);
        req = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_aux",  32'(auxiliar),   32'd0);
        check("post_rst_to",   32'(timeout),    32'd0);
        check("post_rst_toid", 32'(timeout_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rtc_bus_arbiter.md
# rtc_bus_arbiter

Shares the single RTC access port (address, data, read/write strobe, `flag_rtc` ownership flag and `siga`/`tome` handshake) among three requesters: the time writer, the date writer and the periodic display reader. It sits between those sequencers and the RTC bus controller and grants the bus to one requester at a time. A watchdog revokes a grant that is held too long. A one-cycle gap separates consecutive owners.

## Interface
- `TIMEOUT_CYC`, default 1023: maximum cycles a grant may be held before forced revocation; range 1..65535.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  3  request per requester; bit i = requester i (0 time writer, 1 date writer, 2 reader).
- `done`  in  3  release pulse from requester i; ignored unless requester i holds the grant.
- `dir_in`  in  24  requester addresses; bits [8i+7:8i] belong to requester i.
- `dato_in`  in  24  requester write data, same packing.
- `le_in`  in  3  requester read/write strobe (`lea_escriba` value).
- `siga`  in  1  bus-controller step acknowledge.
- `tome`  in  1  bus-controller read-data-valid.
- `grant`  out  3  one-hot grant; all zero when no owner.
- `direc`  out  8  address to the bus controller.
- `dato_smh`  out  8  write data to the bus controller.
- `lea_escriba`  out  1  read/write strobe to the bus controller.
- `flag_rtc`  out  1  high while a requester owns the bus.
- `siga_o`  out  3  `siga & grant[i]`.
- `tome_o`  out  3  `tome & grant[i]`.
- `timeout`  out  1  one-cycle pulse on forced revocation.
- `timeout_id`  out  2  index of the revoked requester; held until the next timeout.
- `auxiliar`  out  4  state code for debug: IDLE=0, BUSY=1, GAP=2.

## Operation
- FSM states are IDLE, BUSY and GAP. State, grant register, watchdog counter and round-robin pointer are registered.
- **IDLE**
  - `grant`=0 and `flag_rtc`=0.
  - If `req` is nonzero, select a winner, load `grant` with the winner's one-hot, clear the watchdog and go to BUSY.
- **BUSY**
  - `flag_rtc`=1.
  - `direc`, `dato_smh` and `lea_escriba` are combinationally muxed from the granted requester's inputs.
  - The watchdog increments each cycle.
  - If `done[g]`=1, or `req[g]` falls, go to GAP with no timeout.
  - Otherwise, if the watchdog equals `TIMEOUT_CYC`-1, go to GAP, pulse `timeout` and load `timeout_id`=g.
  - If release and timeout coincide, release wins and there is no pulse.
- **GAP**
  - `grant`=0 and `flag_rtc`=0.
  - Always returns to IDLE after one cycle.
- **Idle output values** (IDLE or GAP): `direc`=8'h00, `dato_smh`=8'h00, `lea_escriba`=1, `siga_o`=0, `tome_o`=0. No output is ever driven high-impedance.
- **Selection**: fixed priority, 0 > 1 > 2, unless round-robin is compiled in (see Configuration).
- **Revoked requester**: if it still holds `req`, it re-enters arbitration normally and carries no penalty.
- **Reset** (asserted at any time, including mid-grant): state=IDLE, `grant`=0, watchdog=0, RR pointer=2 (so requester 0 is first), `timeout`=0, `timeout_id`=0. All bus outputs take their idle values immediately.

## Timing
- Request to grant: `req` high at edge k while in IDLE gives `grant` and `flag_rtc` high after edge k+1.
- Release: `done` sampled at edge m gives `grant`=0 after edge m+1 (GAP). IDLE is reached after m+2. The earliest next grant is after m+3.
- Watchdog: a grant taken at edge g is revoked after edge g+`TIMEOUT_CYC`. `timeout` is high for exactly that one cycle.
- The bus-output mux adds zero latency relative to the requester inputs.
- Minimum ownership is 1 cycle. Maximum ownership is `TIMEOUT_CYC` cycles.

## Configuration
- Macro: `RTC_ARB_RR_EN`.
- **Defined**: round-robin arbitration.
  - The pointer holds the index of the last granted requester.
  - The search starts at pointer+1, modulo 3.
  - The pointer updates on each IDLE→BUSY transition.
- **Undefined**: fixed priority, 0 > 1 > 2. The pointer logic is absent.

## Test plan
- **Reset and idle**: with `req`=3'b000 after reset release, expect `grant`=0, `flag_rtc`=0, `direc`=8'h00, `lea_escriba`=1 and `auxiliar`=0 for 20 cycles.
- **Single owner**:
  - Stimulus: `req`=3'b010, `dir_in[15:8]`=8'h21, `dato_in[15:8]`=8'h45.
  - Expect `grant`=3'b010 one cycle later, with `direc`=8'h21 and `dato_smh`=8'h45.
  - `siga` pulses appear only on `siga_o[1]`.
  - After a `done[1]` pulse, `grant`=0 for exactly one GAP cycle.
- **Contention**:
  - Stimulus: `req`=3'b111 held, with each owner pulsing `done` after 5 cycles.
  - Fixed priority: requester 0 is re-granted every time.
  - With `RTC_ARB_RR_EN`: the grant order is 0, 1, 2, 0.
- **Watchdog**:
  - Stimulus: `TIMEOUT_CYC`=8, `req`=3'b100 held, `done` never asserted.
  - Expect `grant` high for exactly 8 cycles, then a single `timeout` pulse with `timeout_id`=2, then a re-grant 2 cycles later.
- **Coincidence**: `done[g]` asserted on the watchdog's final cycle → release with no `timeout` pulse.
- **Reset mid-grant**: assert `reset`=0 while `grant`=3'b001 → `grant` and `flag_rtc` clear asynchronously, before the next clock edge.
